controlador_temporizador: RTL and testbench
===========================================

// Module: controlador_temporizador
// PURPOSE
//  Sequencing FSM for the external contador_0_99 BCD counter. Converts start/pause/clear buttons
//  into single-cycle counter pulses at a prescaled rate, selects up/down, gates auto-repor, and
//  stops at the terminal value (99 counting up, 00 counting down). Sits between the board inputs
//  and the counter; the counter's BCD outputs feed back here for terminal detection.
// PARAMETERS
//  DIV_TICK  50_000_000  clocks per counter step (>=2); benches use 4
//  LARG_DIV  26          prescaler width; must satisfy 2**LARG_DIV > DIV_TICK-1
// PORTS
//  clock            in   1  system clock, rising edge
//  reset            in   1  asynchronous, active-low reset
//  btn_iniciar      in   1  start/resume button, asynchronous level
//  btn_pausar       in   1  pause button, asynchronous level
//  btn_zerar        in   1  clear button, asynchronous level
//  modo_decr        in   1  1 = count down, 0 = count up; latched on start
//  auto_repor_en    in   1  allows auto-repor on each step
//  dez              in   4  BCD tens from counter
//  uni              in   4  BCD units from counter
//  cont_pulso       out  1  one-cycle-high step strobe to counter clock input
//  cont_inc         out  1  direction to counter (1 = increment)
//  cont_reset       out  1  active-high one-cycle clear to counter
//  cont_auto_repor  out  1  auto-repor to counter, valid only while cont_pulso = 1
//  estado           out  2  FSM state: 00 OCIOSO, 01 CONTANDO, 10 PAUSADO, 11 FIM
//  fim              out  1  one-cycle pulse on entry to FIM
// BEHAVIOUR
//  - Reset low: estado = OCIOSO, prescaler = 0, sync flops = 0, cont_inc = 1, all other outputs 0.
//  - Buttons: 2-FF synchroniser, then rising-edge detect. Edge strobe asserts 2 clocks after the
//    first sampling edge; estado changes on the 3rd rising edge after the button goes high.
//    Holding a button generates exactly one event.
//  - Priority within one cycle: zerar > pausar > iniciar.
//  - terminal = (modo latched up AND dez==9 AND uni==9) OR (down AND dez==0 AND uni==0).
//    Non-BCD codes (>9) are never terminal.
//  - OCIOSO: iniciar -> latch cont_inc = ~modo_decr, clear prescaler, go to CONTANDO.
//    If terminal is already true, go to FIM instead and pulse fim.
//  - CONTANDO: prescaler counts 0..DIV_TICK-1 and wraps. At DIV_TICK-1:
//      not terminal -> cont_pulso = 1 for one cycle;
//      terminal -> no pulse, go to FIM, fim = 1 for one cycle.
//    First pulse comes DIV_TICK clocks after entry.
//    pausar -> PAUSADO with the prescaler frozen (value held).
//  - PAUSADO: no pulses; iniciar -> CONTANDO, prescaler resumes from the held value.
//    modo_decr changes are ignored.
//  - FIM: no pulses; iniciar and pausar are ignored.
//  - zerar (any state): cont_reset = 1 for one cycle, prescaler = 0, go to OCIOSO, cont_inc kept.
//  - cont_auto_repor = cont_pulso AND auto_repor_en; otherwise 0.
//  - cont_inc changes only on a start from OCIOSO. All outputs are registered (no combinational
//    path from inputs), except cont_auto_repor, which is an AND of registered cont_pulso and the
//    input auto_repor_en.
//  - Reset asserted mid-operation forces the reset values immediately, with no pulse glitch.
// STRUCTURE
//  - Shared header controlador_defs.vh: state codes (EST_OCIOSO..EST_FIM) and BCD constants
//    (BCD_NOVE = 4'd9, BCD_ZERO = 4'd0).
//  - Sub-module sincronizador_borda (2-FF sync + edge detect, ports clock, reset, d, borda),
//    instantiated once per button.
//  - Prescaler and FSM live in this module.
// TESTING (DIV_TICK = 4; the bench models the counter: cont_pulso steps uni/dez per cont_inc)
//  1. Reset low with buttons idle -> estado = 00, cont_inc = 1, cont_pulso = cont_reset = fim = 0.
//  2. Up mode from 97, iniciar pulse -> estado 01 after 3 clocks; pulses at +4 and +8 clocks
//     (98, 99); at +12 no pulse, fim high 1 cycle, estado = 11.
//  3. Pause after 2 prescaler clocks, hold 10 clocks -> no pulse. Resume -> next pulse exactly
//     2 clocks after estado returns to 01.
//  4. Down mode from 03 -> cont_inc = 0, 3 pulses 4 clocks apart (02, 01, 00), then FIM.
//     iniciar in FIM is ignored.
//  5. zerar and pausar in the same cycle while CONTANDO -> cont_reset high 1 cycle, estado = 00,
//     no cont_pulso afterwards.
//  6. Reset low mid-count with the prescaler at 3 -> outputs take reset values before the next edge.
//     Also: auto_repor_en = 1 -> cont_auto_repor high only during each cont_pulso.

Source files
------------

// File: rtl/controlador_temporizador_pkg.sv
// Shared state codes, BCD constants and terminal-value helper for the counter sequencer.
`default_nettype none

package controlador_temporizador_pkg;

    typedef enum logic [1:0] {
        EST_OCIOSO   = 2'b00,
        EST_CONTANDO = 2'b01,
        EST_PAUSADO  = 2'b10,
        EST_FIM      = 2'b11
    } estado_e;

    localparam logic [3:0] BCD_NOVE = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Codes above 9 never match either terminal value.
    function automatic logic eh_terminal(input logic       incr,
                                         input logic [3:0] d,
                                         input logic [3:0] u);
        if (incr) begin
            return (d == BCD_NOVE) && (u == BCD_NOVE);
        end
        return (d == BCD_ZERO) && (u == BCD_ZERO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_temporizador_sincronizador_borda.sv
// Two-flop synchroniser followed by a rising-edge detector for one asynchronous button.
`default_nettype none

module sincronizador_borda (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic borda
);

    logic [1:0] sinc_q;
    logic       anterior_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_q     <= 2'b00;
            anterior_q <= 1'b0;
        end else begin
            sinc_q     <= {sinc_q[0], d};
            anterior_q <= sinc_q[1];
        end
    end

    assign borda = sinc_q[1] & ~anterior_q;

endmodule

`default_nettype wire

// File: rtl/controlador_temporizador.sv
// Button-driven sequencer for the contador_0_99 BCD counter: prescaled step strobes,
// direction latch, pause/resume and stop at the terminal value.
`default_nettype none

module controlador_temporizador
    import controlador_temporizador_pkg::*;
#(
    parameter int DIV_TICK = 50_000_000,
    parameter int LARG_DIV = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_iniciar,
    input  logic       btn_pausar,
    input  logic       btn_zerar,
    input  logic       modo_decr,
    input  logic       auto_repor_en,
    input  logic [3:0] dez,
    input  logic [3:0] uni,
    output logic       cont_pulso,
    output logic       cont_inc,
    output logic       cont_reset,
    output logic       cont_auto_repor,
    output logic [1:0] estado,
    output logic       fim
);

    localparam logic [LARG_DIV-1:0] PRESC_ULTIMO = LARG_DIV'(DIV_TICK - 1);

    logic w_borda_iniciar;
    logic w_borda_pausar;
    logic w_borda_zerar;

    sincronizador_borda u_sinc_iniciar (
        .clock (clock),
        .reset (reset),
        .d     (btn_iniciar),
        .borda (w_borda_iniciar)
    );

    sincronizador_borda u_sinc_pausar (
        .clock (clock),
        .reset (reset),
        .d     (btn_pausar),
        .borda (w_borda_pausar)
    );

    sincronizador_borda u_sinc_zerar (
        .clock (clock),
        .reset (reset),
        .d     (btn_zerar),
        .borda (w_borda_zerar)
    );

    estado_e             estado_q;
    logic [LARG_DIV-1:0] presc_q;
    logic                cont_pulso_q;
    logic                cont_inc_q;
    logic                cont_reset_q;
    logic                fim_q;

    logic w_terminal_atual;
    logic w_terminal_partida;
    logic w_presc_fim;
    logic w_iniciar;

    // A start must judge the terminal value against the direction being latched now.
    assign w_terminal_atual   = eh_terminal(cont_inc_q, dez, uni);
    assign w_terminal_partida = eh_terminal(~modo_decr, dez, uni);
    assign w_presc_fim        = (presc_q == PRESC_ULTIMO);
    assign w_iniciar          = w_borda_iniciar & ~w_borda_pausar;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= EST_OCIOSO;
            presc_q      <= '0;
            cont_pulso_q <= 1'b0;
            cont_inc_q   <= 1'b1;
            cont_reset_q <= 1'b0;
            fim_q        <= 1'b0;
        end else begin
            cont_pulso_q <= 1'b0;
            cont_reset_q <= 1'b0;
            fim_q        <= 1'b0;

            if (w_borda_zerar) begin
                cont_reset_q <= 1'b1;
                presc_q      <= '0;
                estado_q     <= EST_OCIOSO;
            end else begin
                case (estado_q)
                    EST_OCIOSO: begin
                        if (w_iniciar) begin
                            cont_inc_q <= ~modo_decr;
                            presc_q    <= '0;
                            if (w_terminal_partida) begin
                                estado_q <= EST_FIM;
                                fim_q    <= 1'b1;
                            end else begin
                                estado_q <= EST_CONTANDO;
                            end
                        end
                    end

                    EST_CONTANDO: begin
                        if (w_borda_pausar) begin
                            estado_q <= EST_PAUSADO;
                        end else if (w_presc_fim) begin
                            presc_q <= '0;
                            if (w_terminal_atual) begin
                                estado_q <= EST_FIM;
                                fim_q    <= 1'b1;
                            end else begin
                                cont_pulso_q <= 1'b1;
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end

                    EST_PAUSADO: begin
                        if (w_iniciar) begin
                            estado_q <= EST_CONTANDO;
                        end
                    end

                    EST_FIM: begin
                        estado_q <= EST_FIM;
                    end

                    default: begin
                        estado_q <= EST_OCIOSO;
                    end
                endcase
            end
        end
    end

    assign cont_pulso      = cont_pulso_q;
    assign cont_inc        = cont_inc_q;
    assign cont_reset      = cont_reset_q;
    assign fim             = fim_q;
    assign estado          = estado_q;
    assign cont_auto_repor = cont_pulso_q & auto_repor_en;

endmodule

`default_nettype wire

// File: tb/tb_controlador_temporizador.sv
// Directed bench for controlador_temporizador with an emulated BCD counter and an event scoreboard.
`default_nettype none

module tb_controlador_temporizador;

    localparam logic [1:0] S_OCIOSO   = 2'b00;
    localparam logic [1:0] S_CONTANDO = 2'b01;
    localparam logic [1:0] S_PAUSADO  = 2'b10;
    localparam logic [1:0] S_FIM      = 2'b11;

    logic       clock;
    logic       reset;
    logic [2:0] btns;
    logic       modo_decr;
    logic       auto_en;
    logic [3:0] dez;
    logic [3:0] uni;
    logic       cont_pulso;
    logic       cont_inc;
    logic       cont_reset;
    logic       cont_auto_repor;
    logic [1:0] estado;
    logic       fim;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int exp_pulso[$];
    int exp_fim[$];

    controlador_temporizador #(
        .DIV_TICK (4),
        .LARG_DIV (3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .btn_iniciar     (btns[0]),
        .btn_pausar      (btns[1]),
        .btn_zerar       (btns[2]),
        .modo_decr       (modo_decr),
        .auto_repor_en   (auto_en),
        .dez             (dez),
        .uni             (uni),
        .cont_pulso      (cont_pulso),
        .cont_inc        (cont_inc),
        .cont_reset      (cont_reset),
        .cont_auto_repor (cont_auto_repor),
        .estado          (estado),
        .fim             (fim)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock; scoreboard the strobes, then let the emulated counter react.
    task automatic tick();
        logic w_p;
        logic w_f;
        @(negedge clock);
        cyc++;
        w_p = (exp_pulso.size() > 0) && (exp_pulso[0] == cyc);
        w_f = (exp_fim.size() > 0) && (exp_fim[0] == cyc);
        chk("cont_pulso", cont_pulso, w_p);
        chk("fim", fim, w_f);
        chk("cont_auto_repor", cont_auto_repor, w_p & auto_en);
        if (w_p) void'(exp_pulso.pop_front());
        if (w_f) void'(exp_fim.pop_front());
        if (cont_reset) begin
            dez = 4'd0;
            uni = 4'd0;
        end else if (cont_pulso) begin
            if (cont_inc) begin
                if (uni == 4'd9) begin
                    uni = 4'd0;
                    dez = (dez == 4'd9) ? 4'd0 : dez + 4'd1;
                end else begin
                    uni = uni + 4'd1;
                end
            end else begin
                if (uni == 4'd0) begin
                    uni = 4'd9;
                    dez = (dez == 4'd0) ? 4'd9 : dez - 4'd1;
                end else begin
                    uni = uni - 4'd1;
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tick_until(input int alvo);
        while (cyc < alvo) tick();
    endtask

    // Press one button; the state must change on the third edge after the press.
    task automatic press(input int which, input logic [1:0] exp_est, input logic exp_rst, input string tag);
        btns[which] = 1'b1;
        ticks(3);
        chk({tag, "_estado"}, estado, exp_est);
        chk({tag, "_cont_reset"}, cont_reset, exp_rst);
        tick();
        btns = 3'b000;
    endtask

    int e;
    int r;

    initial begin
        reset     = 1'b0;
        btns      = 3'b000;
        modo_decr = 1'b0;
        auto_en   = 1'b0;
        dez       = 4'd0;
        uni       = 4'd0;

        ticks(3);
        chk("rst_estado", estado, S_OCIOSO);
        chk("rst_cont_inc", cont_inc, 1'b1);
        chk("rst_cont_reset", cont_reset, 1'b0);
        reset = 1'b1;
        ticks(2);

        // Up from 97: steps to 98, 99, then stop.
        dez = 4'd9; uni = 4'd7;
        e = cyc + 3;
        exp_pulso.push_back(e + 4);
        exp_pulso.push_back(e + 8);
        exp_fim.push_back(e + 12);
        press(0, S_CONTANDO, 1'b0, "up_start");
        chk("up_cont_inc", cont_inc, 1'b1);
        tick_until(e + 12);
        chk("up_estado_fim", estado, S_FIM);
        chk("up_dez", dez, 4'd9);
        chk("up_uni", uni, 4'd9);
        ticks(2);
        press(0, S_FIM, 1'b0, "up_fim_ignora");
        press(2, S_OCIOSO, 1'b1, "up_zerar");

        // Pause two clocks into a step period, then resume.
        e = cyc + 3;
        exp_pulso.push_back(e + 4);
        press(0, S_CONTANDO, 1'b0, "pausa_start");
        tick_until(e + 4);
        press(1, S_PAUSADO, 1'b0, "pausa");
        ticks(10);
        chk("pausa_estado", estado, S_PAUSADO);
        r = cyc + 3;
        exp_pulso.push_back(r + 2);
        exp_pulso.push_back(r + 6);
        press(0, S_CONTANDO, 1'b0, "retoma");
        tick_until(r + 6);
        chk("retoma_uni", uni, 4'd3);

        // Clear and pause in the same cycle: clear wins.
        btns = 3'b110;
        ticks(3);
        chk("zp_estado", estado, S_OCIOSO);
        chk("zp_cont_reset", cont_reset, 1'b1);
        tick();
        btns = 3'b000;
        ticks(8);
        chk("zp_estado_apos", estado, S_OCIOSO);

        // Down from 03.
        dez = 4'd0; uni = 4'd3; modo_decr = 1'b1;
        e = cyc + 3;
        exp_pulso.push_back(e + 4);
        exp_pulso.push_back(e + 8);
        exp_pulso.push_back(e + 12);
        exp_fim.push_back(e + 16);
        press(0, S_CONTANDO, 1'b0, "down_start");
        chk("down_cont_inc", cont_inc, 1'b0);
        tick_until(e + 16);
        chk("down_estado_fim", estado, S_FIM);
        chk("down_uni", uni, 4'd0);
        ticks(2);
        press(0, S_FIM, 1'b0, "down_fim_ignora");
        press(2, S_OCIOSO, 1'b1, "down_zerar");
        chk("down_inc_mantido", cont_inc, 1'b0);

        // Start while already at the terminal value goes straight to FIM.
        exp_fim.push_back(cyc + 3);
        press(0, S_FIM, 1'b0, "term_start");
        press(2, S_OCIOSO, 1'b1, "term_zerar");

        // Auto-repor gating, then reset mid-count with the prescaler at 3.
        dez = 4'd5; uni = 4'd0; auto_en = 1'b1;
        e = cyc + 3;
        exp_pulso.push_back(e + 4);
        exp_pulso.push_back(e + 8);
        press(0, S_CONTANDO, 1'b0, "ar_start");
        tick_until(e + 11);
        chk("ar_uni", uni, 4'd8);
        reset = 1'b0;
        #1;
        chk("rmid_estado", estado, S_OCIOSO);
        chk("rmid_cont_inc", cont_inc, 1'b1);
        chk("rmid_cont_pulso", cont_pulso, 1'b0);
        chk("rmid_cont_reset", cont_reset, 1'b0);
        chk("rmid_fim", fim, 1'b0);
        ticks(3);
        reset = 1'b1;
        auto_en = 1'b0;
        modo_decr = 1'b0;
        ticks(6);
        chk("rmid_estado_apos", estado, S_OCIOSO);

        chk("fila_pulso_vazia", exp_pulso.size(), 0);
        chk("fila_fim_vazia", exp_fim.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
